// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction fetch controller with redirect, stall, end-marker halt and delivery count
module imem_fetch_ctrl #(
   parameter int         DEPTH    = 64,
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [7:0]  fetch_pc,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [7:0]  redirect_pc,
   input  logic        id_ready,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [7:0]  id_pc,
   output logic        halted,
   output logic        fetch_err,
   output logic [15:0] fetch_count
);
   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
   state_t      state, state_n;
   logic [7:0]  pc, pc_n;
   logic        vld_n, cap, err_set, hs, bad, last;
   assign hs       = id_valid & id_ready;
   assign bad      = 32'(redirect_pc) >= DEPTH;
   assign last     = pc == 8'(DEPTH - 1);
   assign fetch_pc = pc;
   assign halted   = state == HALT;
   // Redirect outranks everything; a zero word ends the program without being delivered.
   always_comb begin
      state_n = state;
      pc_n    = pc;
      vld_n   = id_valid;
      cap     = 1'b0;
      err_set = 1'b0;
      case (state)
         IDLE: state_n = start ? RUN : IDLE;
         RUN, HALT:
            if (redirect_valid) begin
               pc_n    = redirect_pc;
               vld_n   = 1'b0;
               err_set = bad;
               state_n = bad ? HALT : RUN;
            end else if (state == RUN && (!id_valid || id_ready)) begin
               if (imem_instr == 32'h0) begin
                  vld_n   = 1'b0;
                  state_n = HALT;
               end else begin
                  cap     = 1'b1;
                  vld_n   = 1'b1;
                  pc_n    = last ? pc : pc + 8'd1;
                  state_n = last ? HALT : RUN;
               end
            end else if (state == HALT && hs) begin
               vld_n = 1'b0;
            end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         id_valid    <= 1'b0;
         id_instr    <= 32'h0;
         id_pc       <= 8'h0;
         fetch_err   <= 1'b0;
         fetch_count <= 16'h0;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         id_valid  <= vld_n;
         fetch_err <= fetch_err | err_set;
         if (cap) begin
            id_instr <= imem_instr;
            id_pc    <= pc;
         end
         if (hs && fetch_count != 16'hFFFF)
            fetch_count <= fetch_count + 16'd1;
      end
   end
endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words in the instruction memory; legal word indices are 0..DEPTH-1.
REQ-002 Parameter RESET_PC, default 8'h00: word index loaded into the PC at reset.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 start  input  1: one-cycle pulse; begins fetching from IDLE.
REQ-006 fetch_pc  output  8: word index driven to the instruction memory address port (no byte shift).
REQ-007 imem_instr  input  32: combinational read data for fetch_pc, valid in the same cycle.
REQ-008 redirect_valid  input  1: branch/jump redirect request.
REQ-009 redirect_pc  input  8: target word index of the redirect.
REQ-010 id_ready  input  1: decode stage accepts the id_* payload this cycle.
REQ-011 id_valid  output  1: id_instr/id_pc hold a fetched instruction.
REQ-012 id_instr  output  32: registered instruction word.
REQ-013 id_pc  output  8: word index that id_instr was fetched from.
REQ-014 halted  output  1: high while in HALT.
REQ-015 fetch_err  output  1: sticky flag for a redirect target >= DEPTH.
REQ-016 fetch_count  output  16: number of instructions delivered (id_valid && id_ready), saturating.

Function
REQ-017 FSM states SHALL be IDLE, RUN and HALT; fetch_pc SHALL always equal the internal PC register.
REQ-018 IDLE: no fetch, id_valid=0; start=1 -> RUN. redirect_valid is ignored in IDLE.
REQ-019 RUN redirect: redirect_valid=1 SHALL have top priority; next cycle PC=redirect_pc and id_valid=0 (the pending payload is flushed, even if id_ready=1), state stays RUN.
REQ-020 RUN fetch: if !redirect_valid and (!id_valid or id_ready), the controller SHALL capture imem_instr, set id_instr=imem_instr, id_pc=PC and id_valid=1, and advance PC by 1 (one-cycle fetch latency).
REQ-021 RUN stall: if id_valid=1 and id_ready=0, PC, id_valid, id_instr and id_pc SHALL hold unchanged.
REQ-022 End marker: a captured imem_instr of 32'h0000_0000 SHALL NOT be delivered; id_valid goes to 0, PC holds, and the state moves to HALT.
REQ-023 Last word: a fetch at PC=DEPTH-1 SHALL deliver that word normally and then move to HALT; PC SHALL NOT wrap to 0.
REQ-024 HALT: no new fetch; a pending id_valid SHALL remain until accepted by id_ready, then clear; halted=1.
REQ-025 HALT redirect: redirect_valid=1 SHALL set PC=redirect_pc, clear id_valid, and move to RUN.
REQ-026 Bad target: in RUN or HALT, a redirect_pc >= DEPTH SHALL load the PC, set fetch_err=1, clear id_valid, and move to HALT.
REQ-027 fetch_err SHALL be cleared only by reset.
REQ-028 fetch_count SHALL increment on each cycle with id_valid && id_ready and saturate at 16'hFFFF.
REQ-029 Simultaneous redirect_valid and id_ready: the handshake SHALL count in fetch_count, and the redirect still applies.

Reset
REQ-030 With rst_n=0, the block SHALL asynchronously set state=IDLE, PC=RESET_PC, id_valid=0, id_instr=0, id_pc=0, halted=0, fetch_err=0 and fetch_count=0.
REQ-031 Reset asserted mid-fetch or mid-stall SHALL discard the payload immediately; after release the block waits in IDLE for start.

Verification
REQ-032 Memory words 0..3 = 11,22,33,0, id_ready=1, start pulse -> id_instr 11,22,33 on consecutive cycles with id_pc 0,1,2; then HALT with halted=1 and fetch_count=3.
REQ-033 id_ready=0 for 4 cycles after the first delivery -> id_instr=11 and id_pc=0 held stable, fetch_pc=1 throughout; on release the sequence resumes with 22.
REQ-034 redirect_valid with redirect_pc=8'h10 while id_valid=1 and id_ready=0 -> payload flushed, next id_pc=16.
REQ-035 redirect_pc=8'd70 with DEPTH=64 -> fetch_err=1 and halted=1; a later redirect_pc=5 -> RUN, fetching from 5, fetch_err stays 1.
REQ-036 All memory words nonzero, start at RESET_PC=62 -> words 62 and 63 delivered, then HALT with fetch_pc=63 and no wrap.
REQ-037 rst_n pulsed low while id_valid=1 -> all outputs return to their reset values asynchronously; no delivery occurs until start.
